// File: rtl/mem_pkg.sv
// mem_pkg: shared size encodings, responder states and alignment check for the data-memory path.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        return (size == SZ_HALF && lo[0]) || (size == SZ_WORD && lo != 2'b00);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: little-endian byte-lane merge for stores and sign/zero extension for loads.
module lsu_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        unsigned_i,
    input  logic [31:0] old_word_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_word_i,
    output logic [31:0] store_word_o,
    output logic [31:0] load_data_o
);
    logic [4:0]  sh;
    logic [31:0] mask;
    logic [31:0] shifted;

    always_comb begin
        sh           = (size_i == SZ_BYTE) ? {addr_lo_i, 3'b000} :
                       (size_i == SZ_HALF) ? {addr_lo_i[1], 4'b0000} : 5'd0;
        mask         = (size_i == SZ_BYTE) ? (32'h0000_00FF << sh) :
                       (size_i == SZ_HALF) ? (32'h0000_FFFF << sh) : 32'hFFFF_FFFF;
        store_word_o = (old_word_i & ~mask) | ((wdata_i << sh) & mask);
        shifted      = rdata_word_i >> sh;
        load_data_o  = (size_i == SZ_BYTE) ? {{24{shifted[7] & ~unsigned_i}}, shifted[7:0]} :
                       (size_i == SZ_HALF) ? {{16{shifted[15] & ~unsigned_i}}, shifted[15:0]} :
                       rdata_word_i;
    end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: valid/ready load/store responder over an internal word array,
// one request outstanding, response LATENCY+1 cycles after acceptance.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          write_q, unsigned_q;
    logic [1:0]    size_q;
    logic [31:0]   addr_q, wdata_q;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [31:0]   mem_q [DEPTH_WORDS];
    logic          access;
    logic          acc_write, acc_unsigned, acc_err;
    logic [1:0]    acc_size;
    logic [31:0]   acc_addr, acc_wdata;
    logic [AW-1:0] acc_idx;
    logic [31:0]   cur_word, store_word, load_data;

    // a zero-latency access happens on the accept edge, so it must see the live request
    assign acc_write    = (state_q == IDLE) ? req_write    : write_q;
    assign acc_size     = (state_q == IDLE) ? req_size     : size_q;
    assign acc_unsigned = (state_q == IDLE) ? req_unsigned : unsigned_q;
    assign acc_addr     = (state_q == IDLE) ? req_addr     : addr_q;
    assign acc_wdata    = (state_q == IDLE) ? req_wdata    : wdata_q;
    assign acc_idx      = acc_addr[AW+1:2];
    assign cur_word     = mem_q[acc_idx];
    assign acc_err      = (acc_size == SZ_ILLEGAL) || misaligned(acc_size, acc_addr[1:0]) ||
                          (|(acc_addr[31:2] >> AW));

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    lsu_lane_align u_align (
        .size_i      (acc_size),
        .addr_lo_i   (acc_addr[1:0]),
        .unsigned_i  (acc_unsigned),
        .old_word_i  (cur_word),
        .wdata_i     (acc_wdata),
        .rdata_word_i(cur_word),
        .store_word_o(store_word),
        .load_data_o (load_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        access  = 1'b0;
        case (state_q)
            IDLE: if (req_valid) begin
                cnt_d   = 4'(LATENCY);
                access  = (LATENCY == 0);
                state_d = (LATENCY == 0) ? RESP : WAIT;
            end
            WAIT: begin
                cnt_d   = cnt_q - 4'd1;
                access  = (cnt_q == 4'd1);
                state_d = access ? RESP : WAIT;
            end
            RESP:    state_d = rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
        rdata_d = access ? ((acc_write || acc_err) ? 32'd0 : load_data) : rdata_q;
        err_d   = access ? acc_err : err_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            write_q    <= 1'b0;
            size_q     <= SZ_BYTE;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (state_q == IDLE && req_valid) begin
                write_q    <= req_write;
                size_q     <= req_size;
                unsigned_q <= req_unsigned;
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
        end else if (access && acc_write && !acc_err) begin
            mem_q[acc_idx] <= store_word;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized and directed checks of the responder against a byte-level memory model.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0, rsp_ready = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        z_req_valid = 1'b0, z_req_write = 1'b0, z_rsp_ready = 1'b0;
    logic [1:0]  z_req_size = 2'b10;
    logic [31:0] z_req_addr = '0, z_req_wdata = '0;
    logic        z_req_ready, z_rsp_valid, z_rsp_err;
    logic [31:0] z_rsp_rdata;

    int errors = 0;
    int checks = 0;
    logic [31:0] mem_m [256];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_ready(z_req_ready),
        .req_write(z_req_write), .req_size(z_req_size), .req_unsigned(1'b0),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata), .rsp_valid(z_rsp_valid),
        .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    function automatic void clear_model();
        for (int i = 0; i < 256; i++) mem_m[i] = '0;
    endfunction

    // byte-by-byte reference: computes the expected response and updates the model array
    function automatic void model(input logic w, input logic [1:0] sz, input logic u,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic er);
        int n, idx, off;
        logic [31:0] v;
        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off = int'(a % 4);
        er  = (sz == 2'd3) || (a % n != 0) || (a / 4 >= 256);
        rd  = '0;
        if (!er) begin
            idx = int'(a / 4);
            v   = '0;
            for (int k = 0; k < n; k++) begin
                if (w) mem_m[idx][8*(off+k) +: 8] = wd[8*k +: 8];
                else   v[8*k +: 8] = mem_m[idx][8*(off+k) +: 8];
            end
            if (!w && !u && n < 4 && v[8*n-1])
                for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
            rd = w ? 32'd0 : v;
        end
    endfunction

    task automatic xact(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                        input logic [31:0] wd, input int hold,
                        output logic [31:0] rd, output logic er, output int lat);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!rsp_valid) begin
            checks++; errors++;
            $display("FAIL timeout: rsp_valid never rose for addr %h", a);
        end
        rd = rsp_rdata;
        er = rsp_err;
        repeat (hold) @(negedge clk);
        @(negedge clk); rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
    endtask

    task automatic run_and_check(input string name, input logic w, input logic [1:0] sz, input logic u,
                                 input logic [31:0] a, input logic [31:0] wd, input int hold);
        logic [31:0] rd, exp_rd;
        logic        er, exp_er;
        int          lat;
        model(w, sz, u, a, wd, exp_rd, exp_er);
        xact(w, sz, u, a, wd, hold, rd, er, lat);
        checks++;
        if (rd !== exp_rd || er !== exp_er || lat != 3) begin
            errors++;
            $display("FAIL %s: addr=%h got rdata=%h err=%b lat=%0d, want rdata=%h err=%b lat=3",
                     name, a, rd, er, lat, exp_rd, exp_er);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset: ready=%b valid=%b rdata=%h err=%b, want 1 0 0 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
    endtask

    task automatic test_word_roundtrip();
        run_and_check("word_store", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0);
        run_and_check("word_load", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_handshake: ready=%b valid=%b, want 1 0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_extension();
        run_and_check("ext_store", 1'b1, 2'd2, 1'b0, 32'h20, 32'h80FF7F01, 1);
        run_and_check("ld_b_signed", 1'b0, 2'd0, 1'b0, 32'h22, 32'h0, 0);
        run_and_check("ld_b_unsigned", 1'b0, 2'd0, 1'b1, 32'h23, 32'h0, 0);
        run_and_check("ld_h_signed_lo", 1'b0, 2'd1, 1'b0, 32'h20, 32'h0, 0);
        run_and_check("ld_h_signed_hi", 1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 2);
        run_and_check("ld_h_unsigned_hi", 1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 0);
    endtask

    task automatic test_partial_store();
        run_and_check("part_word", 1'b1, 2'd2, 1'b0, 32'h30, 32'h11223344, 0);
        run_and_check("part_byte", 1'b1, 2'd0, 1'b0, 32'h31, 32'hFFFFFFAA, 0);
        run_and_check("part_half", 1'b1, 2'd1, 1'b0, 32'h32, 32'h0000BEEF, 0);
        run_and_check("part_readback", 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 0);
    endtask

    task automatic test_faults();
        run_and_check("f_half_odd", 1'b0, 2'd1, 1'b0, 32'h41, 32'h0, 0);
        run_and_check("f_word_oob", 1'b1, 2'd2, 1'b0, 32'h402, 32'h12345678, 0);
        run_and_check("f_word_oob_al", 1'b1, 2'd2, 1'b0, 32'h400, 32'h12345678, 0);
        run_and_check("f_alias_0", 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 0);
        run_and_check("f_top_word", 1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0, 0);
        run_and_check("f_size11", 1'b1, 2'd3, 1'b0, 32'h44, 32'h55555555, 0);
        run_and_check("f_size11_rb", 1'b0, 2'd2, 1'b0, 32'h44, 32'h0, 0);
    endtask

    task automatic test_backpressure();
        int lat;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h10;
        @(posedge clk); #1;
        req_write = 1'b1; req_wdata = 32'h0BADF00D;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== mem_m[4] || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure[%0d]: valid=%b rdata=%h err=%b ready=%b, want 1 %h 0 0",
                         c, rsp_valid, rsp_rdata, rsp_err, req_ready, mem_m[4]);
            end
            @(posedge clk); #1;
        end
        @(negedge clk); req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
        run_and_check("bp_no_store", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
    endtask

    task automatic test_rsp_ready_idle();
        @(negedge clk); rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rsp_ready_idle: valid=%b ready=%b, want 0 1", rsp_valid, req_ready);
        end
        @(negedge clk); rsp_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [1:0]  sz;
        for (int t = 0; t < 60; t++) begin
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = ($urandom_range(0, 7) == 0) ? 32'h400 + $urandom_range(0, 255) : 32'($urandom_range(0, 127));
            run_and_check("random", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
                          $urandom, $urandom_range(0, 3));
        end
    endtask

    task automatic test_latency0();
        int lat;
        logic [31:0] exp [2];
        exp[0] = 32'd0;
        exp[1] = 32'h12345678;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            z_req_valid = 1'b1; z_req_write = (k == 0); z_req_size = 2'd2;
            z_req_addr = 32'h8; z_req_wdata = 32'h12345678;
            @(posedge clk); #1;
            z_req_valid = 1'b0;
            lat = 1;
            while (!z_rsp_valid && lat < 40) begin
                @(posedge clk); #1;
                lat++;
            end
            checks++;
            if (lat != 1 || z_rsp_rdata !== exp[k] || z_rsp_err !== 1'b0) begin
                errors++;
                $display("FAIL latency0[%0d]: lat=%0d rdata=%h err=%b, want 1 %h 0",
                         k, lat, z_rsp_rdata, z_rsp_err, exp[k]);
            end
            @(negedge clk); z_rsp_ready = 1'b1;
            @(posedge clk); #1; z_rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 32'h50; req_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL midop_wait: ready=%b, want 0", req_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL midop_reset: ready=%b valid=%b rdata=%h err=%b, want 1 0 0 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        clear_model();
        @(negedge clk); rst = 1'b1;
        run_and_check("midop_load", 1'b0, 2'd2, 1'b0, 32'h50, 32'h0, 0);
        run_and_check("midop_load_10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
    endtask

    initial begin
        clear_model();
        #12;
        test_reset();
        @(negedge clk); rst = 1'b1;
        test_word_roundtrip();
        test_extension();
        test_partial_store();
        test_faults();
        test_backpressure();
        test_rsp_ready_idle();
        test_random();
        test_latency0();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
